// File: rtl/sm_hex_scan_n.sv
// sm_hex_scan_n: multiplexed seven-segment hex display driver.
//
// Scans DIGITS digits from one packed nibble bus. The display buffer is
// reloaded only at frame boundaries, so a frame never mixes two loads.
// Brightness is set by PWM inside each digit slot, and both anode and
// segment polarity are selectable.
//
// Optional feature: define SM_HEX_SCAN_LZB_EN to enable leading-zero
// blanking. Digits above the highest non-zero nibble are left unlit, and
// digit 0 is always shown.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous active-high reset
//   number         packed nibbles, digit i = number[4i+3:4i], digit 0 rightmost
//   dots           per-digit decimal point request
//   load           capture number/dots into the pending buffer
//   enable         0: all anodes inactive, scanning continues
//   brightness     PWM duty, (brightness+1)/16 of each slot
//   pending        pending buffer not yet committed to the display
//   frame          one-cycle pulse after the digit-index wrap
//   seven_segments {a,b,c,d,e,f,g}, a = bit 6
//   dot            decimal point of the current digit
//   anodes         one-hot digit select
module sm_hex_scan_n #(
    parameter int unsigned DIGITS           = 8,
    parameter int unsigned SCAN_DIV         = 16,
    parameter int unsigned ANODE_ACTIVE_LOW = 1,
    parameter int unsigned SEG_ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  load,
    input  logic                  enable,
    input  logic [3:0]            brightness,
    output logic                  pending,
    output logic                  frame,
    output logic [6:0]            seven_segments,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes
);

    localparam int unsigned NUM_W = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // XOR masks turning active-high "lit"/"selected" into pin polarity
    localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{ANODE_ACTIVE_LOW != 0}};
    localparam logic [6:0]        SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic              DOT_INV = (SEG_ACTIVE_LOW != 0);

    // Active-high a..g pattern for one hex nibble
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

    // State registers
    logic [SCAN_DIV-1:0] scan_cnt_q,  scan_cnt_d;
    logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
    logic [NUM_W-1:0]    pend_num_q,  pend_num_d;
    logic [DIGITS-1:0]   pend_dots_q, pend_dots_d;
    logic                pending_q,   pending_d;
    logic [NUM_W-1:0]    disp_num_q,  disp_num_d;
    logic [DIGITS-1:0]   disp_dots_q, disp_dots_d;
    logic                shown_q,     shown_d;

    // Output registers
    logic                frame_q,     frame_d;
    logic [6:0]          seg_q,       seg_d;
    logic                dot_q,       dot_d;
    logic [DIGITS-1:0]   anodes_q,    anodes_d;

    // Scan position decode
    logic       slot_end;
    logic       wrap;
    logic [3:0] cur_nib;
    logic       cur_dot;
    logic       anode_act;
    logic       visible;
    logic       lz_blank;

    always_comb begin
        slot_end  = &scan_cnt_q;
        wrap      = slot_end && (digit_idx_q == IDX_W'(DIGITS - 1));
        cur_nib   = disp_num_q[{digit_idx_q, 2'b00} +: 4];
        cur_dot   = disp_dots_q[digit_idx_q];
        anode_act = enable && (scan_cnt_q[SCAN_DIV-1 -: 4] <= brightness);
        // Display stays blank after reset until an anode first lights
        visible   = shown_q || anode_act;
    end

`ifdef SM_HEX_SCAN_LZB_EN
    // Blank the current digit when it and every digit above it are zero
    logic upper_nz;

    always_comb begin
        upper_nz = 1'b0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if ((IDX_W'(j) >= digit_idx_q) && (disp_num_q[4*j +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        lz_blank = (digit_idx_q != '0) && !upper_nz;
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Scan counter and digit index
    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_DIV'(1);
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = wrap ? '0 : digit_idx_q + IDX_W'(1);
        end
    end

    // Load / commit: a load on the wrap edge bypasses the pending buffer
    always_comb begin
        pend_num_d  = pend_num_q;
        pend_dots_d = pend_dots_q;
        pending_d   = pending_q;
        disp_num_d  = disp_num_q;
        disp_dots_d = disp_dots_q;
        if (load && wrap) begin
            disp_num_d  = number;
            disp_dots_d = dots;
            pending_d   = 1'b0;
        end else if (load) begin
            pend_num_d  = number;
            pend_dots_d = dots;
            pending_d   = 1'b1;
        end else if (wrap && pending_q) begin
            disp_num_d  = pend_num_q;
            disp_dots_d = pend_dots_q;
            pending_d   = 1'b0;
        end
    end

    // Pin-level outputs for the next cycle
    always_comb begin
        logic [6:0]        seg_lit;
        logic              dot_lit;
        logic [DIGITS-1:0] an_sel;

        seg_lit = 7'b0;
        dot_lit = 1'b0;
        an_sel  = '0;
        if (visible && !lz_blank) begin
            seg_lit = hex_decode(cur_nib);
        end
        if (visible) begin
            dot_lit = cur_dot;
        end
        if (anode_act) begin
            an_sel = DIGITS'(1) << digit_idx_q;
        end
        shown_d  = visible;
        frame_d  = wrap;
        seg_d    = seg_lit ^ SEG_INV;
        dot_d    = dot_lit ^ DOT_INV;
        anodes_d = an_sel ^ AN_INV;
    end

    // All registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            pend_num_q  <= '0;
            pend_dots_q <= '0;
            pending_q   <= 1'b0;
            disp_num_q  <= '0;
            disp_dots_q <= '0;
            shown_q     <= 1'b0;
            frame_q     <= 1'b0;
            seg_q       <= SEG_INV;
            dot_q       <= DOT_INV;
            anodes_q    <= AN_INV;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            pend_num_q  <= pend_num_d;
            pend_dots_q <= pend_dots_d;
            pending_q   <= pending_d;
            disp_num_q  <= disp_num_d;
            disp_dots_q <= disp_dots_d;
            shown_q     <= shown_d;
            frame_q     <= frame_d;
            seg_q       <= seg_d;
            dot_q       <= dot_d;
            anodes_q    <= anodes_d;
        end
    end

    assign pending        = pending_q;
    assign frame          = frame_q;
    assign seven_segments = seg_q;
    assign dot            = dot_q;
    assign anodes         = anodes_q;

endmodule
